button_event_gen: RTL

Converts the clean, debounced level of one push-button into single-cycle event pulses: press, release, long-press, and auto-repeat while held. It sits directly downstream of the button debouncer. Its pulses drive cursor and control logic in the text display, for example cursor stepping with hold-to-repeat. One instance is used per button.

---
 rtl/button_pkg.sv | 14 +
 rtl/button_event_gen.sv | 103 ++++++++++
 2 files changed

// File: rtl/button_pkg.sv
// button_pkg: shared button FSM state encodings and ms-to-cycles helper
package button_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PRESSED = 2'd1,
      LONG    = 2'd2
   } btn_state_t;

   function automatic int ms_to_cycles(input int clk_freq, input int ms);
      return (clk_freq / 1000) * ms;
   endfunction

endpackage

// File: rtl/button_event_gen.sv
// button_event_gen: turns a debounced button level into press/release/long/repeat pulses
module button_event_gen
   import button_pkg::*;
#(
   parameter int CLK_FREQ      = 100_000_000,
   parameter int LONG_PRESS_MS = 500,
   parameter int REPEAT_MS     = 100
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_level,
   output logic press_pulse,
   output logic release_pulse,
   output logic long_pulse,
   output logic repeat_pulse,
   output logic held
);

   localparam int LONG_CYCLES   = ms_to_cycles(CLK_FREQ, LONG_PRESS_MS);
   localparam int REPEAT_CYCLES = ms_to_cycles(CLK_FREQ, REPEAT_MS);
   localparam int MAX_CYCLES    = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
   localparam int CW            = $clog2(MAX_CYCLES + 1);
   localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 1);
   localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_CYCLES - 1);
   localparam logic REP_EN = REPEAT_CYCLES != 0;

   btn_state_t state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic press_nxt, release_nxt, long_nxt, repeat_nxt, held_nxt;

   // next state, counter and pulse decode; release always takes priority over thresholds
   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt + 1'b1;
      press_nxt   = 1'b0;
      release_nxt = 1'b0;
      long_nxt    = 1'b0;
      repeat_nxt  = 1'b0;
      held_nxt    = held;
      case (state)
         IDLE: begin
            cnt_nxt = '0;
            if (btn_level) begin
               state_nxt = PRESSED;
               press_nxt = 1'b1;
               held_nxt  = 1'b1;
            end
         end
         PRESSED: begin
            if (!btn_level) begin
               state_nxt   = IDLE;
               release_nxt = 1'b1;
               held_nxt    = 1'b0;
               cnt_nxt     = '0;
            end else if (cnt == LONG_LAST) begin
               state_nxt = LONG;
               long_nxt  = 1'b1;
               cnt_nxt   = '0;
            end
         end
         LONG: begin
            if (!btn_level) begin
               state_nxt   = IDLE;
               release_nxt = 1'b1;
               held_nxt    = 1'b0;
               cnt_nxt     = '0;
            end else if (!REP_EN) begin
               cnt_nxt = '0;
            end else if (cnt == REP_LAST) begin
               repeat_nxt = 1'b1;
               cnt_nxt    = '0;
            end
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            held_nxt  = 1'b0;
         end
      endcase
   end

   // state, counter and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         cnt           <= '0;
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
         long_pulse    <= 1'b0;
         repeat_pulse  <= 1'b0;
         held          <= 1'b0;
      end else begin
         state         <= state_nxt;
         cnt           <= cnt_nxt;
         press_pulse   <= press_nxt;
         release_pulse <= release_nxt;
         long_pulse    <= long_nxt;
         repeat_pulse  <= repeat_nxt;
         held          <= held_nxt;
      end
   end

endmodule
